// File: rtl/adder_test_pkg.sv
// Shared types and constants for the adder self-test controller:
// FSM states, LFSR tap positions, operand scrambling steps and the LFSR step function.
package adder_test_pkg;

   localparam int DEF_WIDTH = 16;

   // Operand sweep increments applied per pattern index before LFSR scrambling.
   localparam int unsigned A_STEP = 511;
   localparam int unsigned B_STEP = 509;

   localparam int TAP_A = 15;
   localparam int TAP_B = 14;
   localparam int TAP_C = 13;
   localparam int TAP_D = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/adder_lfsr16.sv
// 16-bit Fibonacci LFSR with a parallel data-XOR input, so the same register
// serves as the operand scrambler (data tied to 0) and as a MISR compactor.
module adder_lfsr16
   import adder_test_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        en,
   input  logic [15:0] data,
   output logic [15:0] state
);

   logic [15:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (en) begin
         state_d = lfsr_step(state_q) ^ data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= seed;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// Self-test sequencer for the adder datapath: issues scrambled operand pairs, delays the golden
// sum to match adder latency and tallies mismatches. ADDER_BIST_SIGNATURE_EN adds a result MISR.
module adder_bist_ctrl
   import adder_test_pkg::*;
#(
   parameter int          WIDTH       = DEF_WIDTH,
   parameter int unsigned PATTERNS    = 128,
   parameter int          DUT_LATENCY = 1,
   parameter logic [15:0] SEED        = 16'h0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH:0]   sum_in,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [31:0]      first_fail_idx,
   output logic [15:0]      sig
);

   localparam logic [31:0] LAST_IDX = 32'(PATTERNS - 1);

   typedef struct packed {
      logic           vld;
      logic [31:0]    idx;
      logic [WIDTH:0] exp;
   } dl_entry_t;

   state_e           state_q, state_d;
   logic [31:0]      idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [15:0]      err_q, err_d;
   logic [31:0]      ffi_q, ffi_d;
   logic [15:0]      lfsr_q;
   dl_entry_t        dl_q [DUT_LATENCY];
   dl_entry_t        dl_in, dl_out;

   logic             run_start, issue_next, last_issue;
   logic             cmp_valid, mismatch, last_cmp;
   logic [31:0]      pat_k;
   logic [15:0]      pat_l;

   // lfsr_q holds L_k while pattern k sits on a/b; the next pattern uses its successor.
   adder_lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (run_start),
      .seed  (SEED),
      .en    (state_q == ST_RUN),
      .data  (16'h0000),
      .state (lfsr_q)
   );

   assign last_issue = (idx_q == LAST_IDX);
   assign dl_out     = dl_q[DUT_LATENCY-1];
   assign cmp_valid  = dl_out.vld;
   assign mismatch   = cmp_valid && (dl_out.exp != sum_in);
   assign last_cmp   = cmp_valid && (dl_out.idx == LAST_IDX);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      run_start  = 1'b0;
      issue_next = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               run_start = 1'b1;
            end
         end
         ST_RUN: begin
            if (last_issue) state_d = ST_DRAIN;
            else            issue_next = 1'b1;
         end
         ST_DRAIN: begin
            if (last_cmp) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pat_k = run_start ? 32'd0 : idx_q + 32'd1;
      pat_l = run_start ? SEED : lfsr_step(lfsr_q);
      a_d   = a_q;
      b_d   = b_q;
      idx_d = idx_q;
      if (run_start || issue_next) begin
         a_d   = ({WIDTH{1'b1}} - WIDTH'(pat_k) * WIDTH'(A_STEP)) ^ WIDTH'(pat_l);
         b_d   = (WIDTH'(1) + WIDTH'(pat_k) * WIDTH'(B_STEP)) ^ WIDTH'(pat_l);
         idx_d = pat_k;
      end

      err_d = err_q;
      ffi_d = ffi_q;
      if (run_start) begin
         err_d = '0;
         ffi_d = '0;
      end else if (mismatch) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         if (err_q == 16'h0000) ffi_d = dl_out.idx;
      end

      dl_in.vld = (state_q == ST_RUN);
      dl_in.idx = idx_q;
      dl_in.exp = {1'b0, a_q} + {1'b0, b_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= '0;
         ffi_q   <= '0;
         // NOTE: the golden delay line is reset too; a stale valid bit would score a bogus compare.
         for (int i = 0; i < DUT_LATENCY; i++) dl_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         ffi_q   <= ffi_d;
         dl_q[0] <= dl_in;
         for (int i = 1; i < DUT_LATENCY; i++) dl_q[i] <= dl_q[i-1];
      end
   end

`ifdef ADDER_BIST_SIGNATURE_EN
   logic [15:0] misr_q;

   adder_lfsr16 u_misr (
      .clk   (clk),
      .rst   (rst),
      .load  (run_start),
      .seed  (16'h0000),
      .en    (cmp_valid),
      .data  (sum_in[15:0]),
      .state (misr_q)
   );

   assign sig = misr_q;
`else
   assign sig = 16'h0000;
`endif

   assign a              = a_q;
   assign b              = b_q;
   assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign pass           = (state_q == ST_DONE) && (err_q == 16'h0000);
   assign err_count      = err_q;
   assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl: three controllers (L=1, L=4, long saturating run)
// each driving a behavioural registered adder with optional fault injection.
module tb_adder_bist_ctrl;

   logic clk = 1'b0;
   logic rst, rst2;
   logic start0, start1, start2;
   int   corrupt_idx;
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic [15:0] a0, b0, a1, b1, a2, b2;
   logic [16:0] sum0, sum2;
   logic [16:0] s1 [4];
   logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
   logic [15:0] err0, err1, err2, sig0, sig1, sig2;
   logic [31:0] ffi0, ffi1, ffi2;
   logic [2:0]  done_v;
   int          cyc0, cyc2;

   always #5 clk = ~clk;

   assign done_v = {done2, done1, done0};

   adder_bist_ctrl #(.PATTERNS(128), .DUT_LATENCY(1)) u0 (
      .clk(clk), .rst(rst), .start(start0), .sum_in(sum0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_idx(ffi0), .sig(sig0));

   adder_bist_ctrl #(.PATTERNS(128), .DUT_LATENCY(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .sum_in(s1[3]), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_idx(ffi1), .sig(sig1));

   adder_bist_ctrl #(.PATTERNS(65540), .DUT_LATENCY(1)) u2 (
      .clk(clk), .rst(rst2), .start(start2), .sum_in(sum2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_idx(ffi2), .sig(sig2));

   // Registered adder models; cycN tracks the pattern index sampled at each edge.
   always @(posedge clk) begin
      if (start0) cyc0 <= 0; else cyc0 <= cyc0 + 1;
      sum0 <= ({1'b0, a0} + {1'b0, b0}) ^ 17'(cyc0 == corrupt_idx);
      s1[0] <= {1'b0, a1} + {1'b0, b1};
      for (int i = 1; i < 4; i++) s1[i] <= s1[i-1];
      if (start2) cyc2 <= 0; else cyc2 <= cyc2 + 1;
      sum2 <= ({1'b0, a2} + {1'b0, b2}) ^ 17'(cyc2 >= 3);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits at negedges for done of controller sel; at = cycle index, or -1 if the budget runs out.
   task automatic wait_done(input int sel, input int from, input int budget, output int at);
      int cnt = from;
      while (!done_v[sel] && cnt < from + budget) begin
         @(negedge clk);
         cnt++;
      end
      at = done_v[sel] ? cnt : -1;
   endtask

   int          at;
   logic [15:0] sig_a, sig_b, sig_c;

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      corrupt_idx = -1;
      repeat (3) @(negedge clk);
      check("rst_a", a0, 16'h0);
      check("rst_b", b0, 16'h0);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_pass", pass0, 1'b0);
      check("rst_err", err0, 16'h0);
      check("rst_ffi", ffi0, 32'h0);
      check("rst_sig", sig0, 16'h0);
      rst = 1'b0; rst2 = 1'b0;

      // Long saturating run proceeds in the background on u2.
      start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;

      // Ideal run, L=1.
      start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      check("p0_a", a0, 16'hFFFE);
      check("p0_b", b0, 16'h0000);
      check("p0_busy", busy0, 1'b1);
      @(negedge clk);
      check("p1_a", a0, 16'hFE02);
      check("p1_b", b0, 16'h01FC);
      @(negedge clk);
      check("p2_a", a0, 16'hFC05);
      check("p2_b", b0, 16'h03FF);
      wait_done(0, 2, 1000, at);
      check("ideal_done_cycle", at, 129);
      check("ideal_pass", pass0, 1'b1);
      check("ideal_err", err0, 16'h0);
      check("ideal_ffi", ffi0, 32'h0);
      check("ideal_busy_low", busy0, 1'b0);
      sig_a = sig0;

      // Pattern 5 corrupted.
      corrupt_idx = 5;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      wait_done(0, 0, 1000, at);
      check("c5_done_cycle", at, 129);
      check("c5_err", err0, 16'h1);
      check("c5_ffi", ffi0, 32'd5);
      check("c5_pass", pass0, 1'b0);
      sig_c = sig0;

      // Restart from DONE clears results; then abort at RUN cycle 40.
      corrupt_idx = -1;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      check("restart_err", err0, 16'h0);
      check("restart_ffi", ffi0, 32'h0);
      check("restart_done", done0, 1'b0);
      check("restart_busy", busy0, 1'b1);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy0, 1'b0);
      check("abort_done", done0, 1'b0);
      check("abort_a", a0, 16'h0);
      check("abort_b", b0, 16'h0);
      check("abort_err", err0, 16'h0);
      rst = 1'b0;

      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      check("rerun_p0_a", a0, 16'hFFFE);
      @(negedge clk);
      check("rerun_p1_b", b0, 16'h01FC);
      wait_done(0, 1, 1000, at);
      check("rerun_done_cycle", at, 129);
      check("rerun_pass", pass0, 1'b1);
      check("rerun_err", err0, 16'h0);
      sig_b = sig0;

`ifdef ADDER_BIST_SIGNATURE_EN
      check("sig_repeatable", sig_b, sig_a);
      check("sig_nonzero", sig_a != 16'h0, 1'b1);
      check("sig_detects_error", sig_c != sig_a, 1'b1);
`else
      check("sig_tied_a", sig_a, 16'h0);
      check("sig_tied_c", sig_c, 16'h0);
`endif

      // L=4 run with start pulses in RUN (cycle 50) and DRAIN (cycle 129) that must be ignored.
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      at = 0;
      while (!done1 && at < 1000) begin
         @(negedge clk);
         at++;
         start1 = (at == 50) || (at == 129);
         if (at == 130) check("l4_drain_busy", busy1, 1'b1);
      end
      start1 = 1'b0;
      check("l4_done_cycle", done1 ? at : -1, 132);
      check("l4_pass", pass1, 1'b1);
      check("l4_err", err1, 16'h0);
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      check("l4_restart_done", done1, 1'b0);
      check("l4_restart_busy", busy1, 1'b1);
      check("l4_restart_a", a1, 16'hFFFE);

      // Saturation: every pattern from index 3 on fails, 65537 mismatches in all.
      wait_done(2, 0, 70000, at);
      check("sat_done_seen", at >= 0, 1'b1);
      check("sat_err", err2, 16'hFFFF);
      check("sat_ffi", ffi2, 32'd3);
      check("sat_pass", pass2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
